// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU types: FSM states, default widths, condition-flag bundle
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_CHUNK = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    typedef struct packed {
        logic n;
        logic v;
        logic c;
        logic z;
    } alu_flags_t;

endpackage

// File: rtl/flag_add_slice.sv
// rtl/flag_add_slice.sv - combinational CHUNK-bit ripple adder slice
module flag_add_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    // carry into the slice MSB feeds the signed-overflow flag on the top chunk
    assign c_msb = carry[CHUNK-1];
    assign cout  = carry[CHUNK];

endmodule

// File: rtl/flag_generator.sv
// rtl/flag_generator.sv - multi-cycle add/sub producing N/V/C/Z flags, CHUNK bits per cycle
module flag_generator
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CHUNK = ALU_CHUNK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             FlagN,
    output logic             FlagV,
    output logic             FlagC,
    output logic             FlagZ
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("flag_generator: WIDTH must be a multiple of CHUNK");
    end

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] result_q, result_d;
    alu_flags_t       flags_q, flags_d;

    logic [CHUNK-1:0] slice_a, slice_b, slice_sum;
    logic             slice_cout, slice_c_msb;

    assign slice_a = a_q[idx_q * CHUNK +: CHUNK];
    assign slice_b = b_q[idx_q * CHUNK +: CHUNK];

    flag_add_slice #(.CHUNK(CHUNK)) u_slice (
        .a     (slice_a),
        .b     (slice_b),
        .cin   (carry_q),
        .sum   (slice_sum),
        .cout  (slice_cout),
        .c_msb (slice_c_msb)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // subtraction reuses the adder: A + ~B + 1
                    a_d     = A;
                    b_d     = sub ? ~B : B;
                    carry_d = sub;
                    idx_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                result_d[idx_q * CHUNK +: CHUNK] = slice_sum;
                carry_d = slice_cout;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    flags_d.n = result_d[WIDTH-1];
                    flags_d.c = slice_cout;
                    flags_d.v = slice_c_msb ^ slice_cout;
                    flags_d.z = ~|result_d;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Result    = result_q;
    assign FlagN     = flags_q.n;
    assign FlagV     = flags_q.v;
    assign FlagC     = flags_q.c;
    assign FlagZ     = flags_q.z;

endmodule

// File: tb/tb_flag_generator.sv
// tb/tb_flag_generator.sv - self-checking bench for flag_generator
module tb_flag_generator;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;
    logic        FlagN, FlagV, FlagC, FlagZ;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    flag_generator dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .FlagN     (FlagN),
        .FlagV     (FlagV),
        .FlagC     (FlagC),
        .FlagZ     (FlagZ)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference: plain integer arithmetic, flags from their arithmetic meaning.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] r, output logic n, output logic v,
                         output logic c, output logic z);
        longint sa, sb, sr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sr = s ? (sa - sb) : (sa + sb);
        r  = s ? (a - b) : (a + b);
        c  = s ? (a >= b) : ((longint'(a) + longint'(b)) > 64'hFFFF_FFFF);
        v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        n  = r[31];
        z  = (r == 32'd0);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input int hold);
        logic [31:0] er;
        logic        en, ev, ec, ez;
        int          n;
        int          lat;
        model(a, b, s, er, en, ev, ec, ez);
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_op", in_ready, 1);
        A = a; B = b; sub = s; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        A = $urandom; B = $urandom; sub = $urandom_range(1, 0);
        chk("in_ready_after_accept", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'd4);
        chk("result", Result, er);
        chk("flag_n", FlagN, en);
        chk("flag_v", FlagV, ev);
        chk("flag_c", FlagC, ec);
        chk("flag_z", FlagZ, ez);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            A = $urandom; B = $urandom;
            @(negedge clk);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_result", Result, er);
            chk("hold_flags", {FlagN, FlagV, FlagC, FlagZ}, {en, ev, ec, ez});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_after_hs", out_valid, 0);
        chk("in_ready_after_hs", in_ready, 1);
        chk("result_kept_idle", Result, er);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          seen;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; sub = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_result", Result, 0);
        chk("reset_flags", {FlagN, FlagV, FlagC, FlagZ}, 4'b0000);
        reset = 1'b0;
        @(negedge clk);

        run_op(32'd5, 32'd7, 1'b1, 0);
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
        run_op(32'h0000_1234, 32'h0000_1234, 1'b1, 0);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
        run_op(32'h7FFF_FFFF, 32'd1, 1'b0, 0);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 10);

        // asynchronous reset during the second CALC cycle
        A = 32'hDEAD_BEEF; B = 32'h1234_5678; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_in_ready", in_ready, 1);
        chk("async_rst_result", Result, 0);
        chk("async_rst_flags", {FlagN, FlagV, FlagC, FlagZ}, 4'b0000);
        #1 reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("no_result_after_reset", 64'(seen), 64'd0);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = (i % 6 == 0) ? ra : $urandom;
            if (i % 8 == 3) rb = 32'h8000_0000;
            run_op(ra, rb, 1'(i % 2), int'($urandom_range(3, 0)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
